bit_packer: RTL and testbench
=============================

BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 Parameter: PAD_BIT, default 1'b0, value placed in unused bits of a flushed partial word.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 pushin  input  1  a field is presented this cycle.
REQ-005 lenin  input  4  field length in bits, 0..15.
REQ-006 datain  input  15  field bits, LSB-aligned; bits at index >= lenin are ignored.
REQ-007 flush  input  1  emit any pending bits as a zero-/pad-filled partial word.
REQ-008 pushout  output  1  dataout/validbits valid; single-cycle pulse per word.
REQ-009 dataout  output  32  packed word; the first-received bit sits at bit 0.
REQ-010 validbits  output  6  number of meaningful bits in dataout: 32 for a full word, 1..31 for a flushed partial word.
REQ-011 pending  output  6  bits currently held in the accumulator (0..31).

Function
REQ-012 The block shall be the downstream consumer of the variable-length bit extractor; its input fields use the same LSB-first bit order, so packed words fed back to the extractor reproduce the fields.
REQ-013 State shall consist of a 47-bit accumulator, a 6-bit count cnt (0..31), and an FSM with states RUN and FLUSH2.
REQ-014 Accept rule: on an edge with pushin=1 and lenin=n>0, datain[n-1:0] shall be written to accumulator bits [cnt +: n], and cnt shall become cnt+n.
REQ-015 pushin with lenin=0 shall be a no-op, with no state change.
REQ-016 No backpressure: every field shall be accepted, and at most one full word can complete per cycle because cnt<32 and n<=15.
REQ-017 Word emission: when cnt+n >= 32 at an accept edge, that same edge shall register pushout=1, dataout = the low 32 accumulated bits, and validbits=32; the accumulator shall shift right by 32 and cnt shall become cnt+n-32.
REQ-018 Latency from the completing push edge to pushout shall be one cycle.
REQ-019 pushout shall be 0 on every edge that emits nothing; dataout and validbits shall hold their last values while pushout=0.
REQ-020 Flush in RUN: the same-edge field is included first, giving a total t = cnt+n.
  - t=0: nothing is emitted.
  - 1<=t<=31: emit the partial word (pushout=1, validbits=t, bits [31:t]=PAD_BIT) and set cnt=0.
  - t=32: emit the full word only, with cnt=0.
  - t>32: emit the full word this edge and go to FLUSH2, with cnt=t-32.
REQ-021 FLUSH2: on the next edge, emit the remaining bits as a partial word (validbits=cnt, padded), then return to RUN.
  - A field pushed on that edge shall start a fresh accumulator: it lands at bit 0, with cnt=n.
  - flush asserted in FLUSH2 shall be ignored.
REQ-022 pending shall equal cnt at all times.
REQ-023 Accumulator bits at index >= cnt shall never reach dataout except as PAD_BIT.

Reset
REQ-024 rst_n low shall immediately force the following, regardless of clk or any operation in progress:
  - pushout=0, dataout=0, validbits=0, pending=0;
  - accumulator cleared;
  - FSM in RUN.
REQ-025 A partial word in flight (including FLUSH2) shall be discarded by reset, not emitted.
REQ-026 First accept shall be possible on the first rising edge after rst_n deasserts.

Verification
REQ-027 Assert rst_n=0 asynchronously mid-stream with pending=20 -> outputs 0 and pending=0 before the next clk edge; no word is emitted afterwards.
REQ-028 Eight pushes, lenin=4, datain=1,2,...,8 -> exactly one pulse: dataout=0x87654321, validbits=32, one cycle after the 8th push edge; pending=0.
REQ-029 Three pushes, lenin=15, datain=0x7FFF -> dataout=0xFFFFFFFF after the third push; pending=13; no pulse after pushes 1-2.
REQ-030 Push lenin=3 datain=0b101, then flush alone -> dataout=0x00000005, validbits=3 (PAD_BIT=0); pending=0.
REQ-031 With pending=30 (all ones), push lenin=15 datain=0x7FFF together with flush:
  - cycle 1: dataout=0xFFFFFFFF, validbits=32.
  - cycle 2: dataout=0x00001FFF, validbits=13.
  - then pending=0.
REQ-032 Loopback: 1000 random fields (lenin 0..15) through bit_packer, then the extractor requesting the same lengths -> identical field values; also check lenin=0 pushes and flush with pending=0 produce no pushout.

Source files
------------

// File: rtl/bit_packer.sv
// Packs LSB-first variable-length fields (0..15 bits) into 32-bit words.
// Full words are emitted as soon as 32 bits collect; flush emits a PAD_BIT-filled partial word.
module bit_packer #(
    parameter logic PAD_BIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pushin,
    input  logic [3:0]  lenin,
    input  logic [14:0] datain,
    input  logic        flush,
    output logic        pushout,
    output logic [31:0] dataout,
    output logic [5:0]  validbits,
    output logic [5:0]  pending
);

    typedef enum logic {
        RUN,
        FLUSH2
    } state_t;

    state_t      state;
    logic [46:0] acc;
    logic [5:0]  cnt;

    logic [4:0]  n;
    logic [46:0] field;
    logic [46:0] merged;
    logic [5:0]  t;

    // Keep the low k bits of w; every bit above them becomes PAD_BIT.
    function automatic logic [31:0] pad_word(input logic [31:0] w, input logic [5:0] k);
        logic [31:0] hi;
        hi = 32'hFFFF_FFFF << k;
        return (w & ~hi) | ({32{PAD_BIT}} & hi);
    endfunction

    always_comb begin
        n      = pushin ? {1'b0, lenin} : 5'd0;
        field  = {32'd0, datain & ~(15'h7FFF << lenin)};
        if (!pushin)
            field = '0;
        merged = acc | (field << cnt);
        t      = cnt + {1'b0, n};
    end

    assign pending = cnt;

    // Accumulator bits at or above cnt are always zero, so OR-merging is safe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            acc       <= '0;
            cnt       <= '0;
            pushout   <= 1'b0;
            dataout   <= '0;
            validbits <= '0;
        end else begin
            pushout <= 1'b0;
            case (state)
                RUN: begin
                    if (flush && t != 6'd0 && t < 6'd32) begin
                        pushout   <= 1'b1;
                        dataout   <= pad_word(merged[31:0], t);
                        validbits <= t;
                        acc       <= '0;
                        cnt       <= '0;
                    end else if (t >= 6'd32) begin
                        pushout   <= 1'b1;
                        dataout   <= merged[31:0];
                        validbits <= 6'd32;
                        acc       <= merged >> 32;
                        cnt       <= t - 6'd32;
                        if (flush && t != 6'd32)
                            state <= FLUSH2;
                    end else begin
                        acc <= merged;
                        cnt <= t;
                    end
                end
                FLUSH2: begin
                    // Remainder goes out now; a same-edge field opens a fresh accumulator.
                    pushout   <= 1'b1;
                    dataout   <= pad_word(acc[31:0], cnt);
                    validbits <= cnt;
                    acc       <= field;
                    cnt       <= {1'b0, n};
                    state     <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_packer.sv
// Self-checking bench for bit_packer: bit-queue reference model, directed cases and random loopback.
module tb_bit_packer;

    localparam logic PAD = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pushin;
    logic [3:0]  lenin;
    logic [14:0] datain;
    logic        flush;
    logic        pushout;
    logic [31:0] dataout;
    logic [5:0]  validbits;
    logic [5:0]  pending;

    bit_packer #(.PAD_BIT(PAD)) dut (
        .clk(clk), .rst_n(rst_n), .pushin(pushin), .lenin(lenin), .datain(datain),
        .flush(flush), .pushout(pushout), .dataout(dataout), .validbits(validbits),
        .pending(pending)
    );

    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned total  = 0;

    // Reference model: a plain FIFO of bits plus a "second flush word owed" flag.
    bit          mq[$];
    bit          owe;
    logic        exp_po;
    logic [31:0] exp_do;
    logic [5:0]  exp_vb;

    // Loopback stream rebuilt from the DUT's emitted words.
    bit          lb_on;
    bit          sq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic m_emit(input int unsigned k);
        logic [31:0] w;
        w = {32{PAD}};
        for (int unsigned i = 0; i < k; i++) w[i] = mq.pop_front();
        exp_po = 1'b1;
        exp_do = w;
        exp_vb = 6'(k);
    endtask

    task automatic m_step(input logic p, input logic [3:0] l, input logic [14:0] d, input logic f);
        exp_po = 1'b0;
        if (owe) begin
            m_emit(mq.size());
            owe = 1'b0;
            if (p) for (int unsigned i = 0; i < l; i++) mq.push_back(d[i]);
        end else begin
            if (p) for (int unsigned i = 0; i < l; i++) mq.push_back(d[i]);
            if (f && mq.size() > 0) begin
                if (mq.size() > 32) owe = 1'b1;
                m_emit(mq.size() >= 32 ? 32 : mq.size());
            end else if (mq.size() >= 32) begin
                m_emit(32);
            end
        end
    endtask

    task automatic m_reset();
        mq.delete();
        owe    = 1'b0;
        exp_po = 1'b0;
        exp_do = '0;
        exp_vb = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pushout"},   32'(pushout),   32'(exp_po));
        chk({tag, ".dataout"},   dataout,        exp_do);
        chk({tag, ".validbits"}, 32'(validbits), 32'(exp_vb));
        chk({tag, ".pending"},   32'(pending),   32'(mq.size()));
    endtask

    task automatic step(input string tag, input logic p, input logic [3:0] l,
                        input logic [14:0] d, input logic f);
        pushin = p; lenin = l; datain = d; flush = f;
        @(posedge clk);
        #1;
        m_step(p, l, d, f);
        check_all(tag);
        if (lb_on && pushout)
            for (int unsigned i = 0; i < validbits; i++) sq.push_back(dataout[i]);
        pushin = 1'b0; lenin = '0; datain = '0; flush = 1'b0;
    endtask

    logic [3:0]  lens[1000];
    logic [14:0] vals[1000];

    initial begin
        logic [14:0] got, want;
        logic [3:0]  l;
        logic [14:0] d;
        pushin = 1'b0; lenin = '0; datain = '0; flush = 1'b0;
        lb_on = 1'b0;
        m_reset();

        // Reset state
        rst_n = 1'b0;
        #12;
        check_all("reset");
        #4 rst_n = 1'b1;

        // Eight 4-bit nibbles make exactly one word
        for (int i = 1; i <= 8; i++) begin
            step("nib", 1'b1, 4'd4, 15'(i), 1'b0);
            if (i < 8) chk("nib.no_pulse", 32'(pushout), 32'd0);
        end
        chk("nib.word", dataout, 32'h8765_4321);
        chk("nib.vb", 32'(validbits), 32'd32);
        chk("nib.pending", 32'(pending), 32'd0);

        // Three 15-bit all-ones fields
        step("ones1", 1'b1, 4'd15, 15'h7FFF, 1'b0);
        step("ones2", 1'b1, 4'd15, 15'h7FFF, 1'b0);
        chk("ones.no_pulse", 32'(pushout), 32'd0);
        step("ones3", 1'b1, 4'd15, 15'h7FFF, 1'b0);
        chk("ones.word", dataout, 32'hFFFF_FFFF);
        chk("ones.pending", 32'(pending), 32'd13);
        step("drain_fl", 1'b0, 4'd0, 15'd0, 1'b1);
        chk("drain.word", dataout, 32'h0000_1FFF);
        step("idle", 1'b0, 4'd0, 15'd0, 1'b0);

        // Short field then lone flush
        step("p3", 1'b1, 4'd3, 15'b101, 1'b0);
        step("p3_fl", 1'b0, 4'd0, 15'd0, 1'b1);
        chk("p3.word", dataout, 32'h0000_0005);
        chk("p3.vb", 32'(validbits), 32'd3);
        chk("p3.pending", 32'(pending), 32'd0);

        // Flush with overflow: full word then 13-bit tail; flush during FLUSH2 ignored
        step("ov1", 1'b1, 4'd15, 15'h7FFF, 1'b0);
        step("ov2", 1'b1, 4'd15, 15'h7FFF, 1'b0);
        chk("ov.pending30", 32'(pending), 32'd30);
        step("ov_fl", 1'b1, 4'd15, 15'h7FFF, 1'b1);
        chk("ov.word1", dataout, 32'hFFFF_FFFF);
        chk("ov.vb1", 32'(validbits), 32'd32);
        step("ov_tail", 1'b0, 4'd0, 15'd0, 1'b1);
        chk("ov.word2", dataout, 32'h0000_1FFF);
        chk("ov.vb2", 32'(validbits), 32'd13);
        chk("ov.pending0", 32'(pending), 32'd0);

        // Field pushed during FLUSH2 lands at bit 0 of a fresh accumulator
        step("f2a", 1'b1, 4'd15, 15'h1234, 1'b0);
        step("f2b", 1'b1, 4'd15, 15'h7ABC, 1'b0);
        step("f2c", 1'b1, 4'd7,  15'h5A,   1'b1);
        step("f2d", 1'b1, 4'd5,  15'h7FF3, 1'b1);
        step("f2e", 1'b0, 4'd0,  15'd0,    1'b1);

        // No-op pushes and empty flush
        step("len0", 1'b1, 4'd0, 15'h7FFF, 1'b0);
        step("fl_empty", 1'b0, 4'd0, 15'd0, 1'b1);

        // Asynchronous reset mid-stream with 20 bits pending
        step("r15", 1'b1, 4'd15, 15'h2AAA, 1'b0);
        step("r5",  1'b1, 4'd5,  15'h15,   1'b0);
        chk("rst.pending20", 32'(pending), 32'd20);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        #2 rst_n = 1'b1;
        step("post_rst", 1'b0, 4'd0, 15'd0, 1'b1);
        step("post_rst2", 1'b0, 4'd0, 15'd0, 1'b0);

        // Random loopback with occasional flushes
        lb_on = 1'b1;
        sq.delete();
        for (int i = 0; i < 1000; i++) begin
            l = 4'($urandom_range(0, 15));
            d = 15'($urandom);
            lens[i] = l;
            vals[i] = d;
            step("rnd", 1'b1, l, d, ($urandom_range(0, 15) == 0));
        end
        step("lb_fl", 1'b0, 4'd0, 15'd0, 1'b1);
        step("lb_idle", 1'b0, 4'd0, 15'd0, 1'b0);
        lb_on = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            got  = '0;
            want = '0;
            for (int unsigned b = 0; b < lens[i]; b++) begin
                want[b] = vals[i][b];
                if (sq.size() > 0) got[b] = sq.pop_front();
                else got[b] = 1'bx;
            end
            chk("loopback", 32'(got), 32'(want));
        end
        chk("lb.leftover", 32'(sq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
